count_reg_unit: RTL and testbench

- Parameterised synchronous up-counter with enable and synchronous clear.
- Used by memory-interface controllers as local latency and burst-length counters: cleared while the FSM is idle, advanced while a phase is active, and compared combinationally by the parent.
- Adds a terminal-count flag and an optional saturate mode so parents can drop their own comparators.

---
 rtl/count_reg_if.sv | 13 +
 rtl/count_reg_unit.sv | 54 +++++
 tb/tb_count_reg_unit.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/count_reg_if.sv
// Counter bus between a controller FSM and its local latency/burst counter.
// The parent holds master (drives en); the counter holds slave.
interface count_reg_if #(
    parameter int unsigned WIDTH = 4
);
    logic             en;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrapped;

    modport master (output en, input count, tc, wrapped);
    modport slave  (input en, output count, tc, wrapped);
endinterface

// File: rtl/count_reg_unit.sv
// Synchronous up-counter with enable, synchronous clear, terminal-count flag
// and selectable wrap or saturate behaviour at MAX_COUNT.
module count_reg_unit #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MAX_COUNT = (2 ** WIDTH) - 1,
    parameter bit          SATURATE  = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    count_reg_if.slave        bus
);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    // Power-up value matches the reset state so count is never X.
    logic [WIDTH-1:0] count_q = '0;
    logic             wrapped_q;
    logic             at_max;

    // Values above MAX_VAL are treated as terminal so no illegal state persists.
    assign at_max = (count_q >= MAX_VAL);

    generate
        if (SATURATE) begin : g_sat
            always_ff @(posedge clk) begin
                if (rst) begin
                    count_q <= '0;
                end else if (bus.en) begin
                    count_q <= at_max ? MAX_VAL : count_q + ONE;
                end
            end
            assign wrapped_q = 1'b0;
        end else begin : g_wrap
            logic wrap_q = 1'b0;

            always_ff @(posedge clk) begin
                if (rst) begin
                    count_q <= '0;
                    wrap_q  <= 1'b0;
                end else if (bus.en) begin
                    count_q <= at_max ? '0 : count_q + ONE;
                    wrap_q  <= at_max;
                end else begin
                    wrap_q  <= 1'b0;
                end
            end
            assign wrapped_q = wrap_q;
        end
    endgenerate

    assign bus.count   = count_q;
    assign bus.tc      = (count_q == MAX_VAL);
    assign bus.wrapped = wrapped_q;
endmodule

// File: tb/tb_count_reg_unit.sv
// Bench for count_reg_unit: four instances (wrap, saturate, short wrap, narrow net)
// checked by directed tables, hand sequences and a random run against a modulo model.
module tb_count_reg_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en  = 1'b0;

    always #5 clk = ~clk;

    count_reg_if #(.WIDTH(4)) if_a ();
    count_reg_if #(.WIDTH(2)) if_b ();
    count_reg_if #(.WIDTH(4)) if_c ();
    count_reg_if #(.WIDTH(4)) if_d ();

    assign if_a.en = en;
    assign if_b.en = en;
    assign if_c.en = en;
    assign if_d.en = en;

    logic [1:0] narrow;
    assign narrow = if_d.count[1:0];

    count_reg_unit #(.WIDTH(4), .MAX_COUNT(15), .SATURATE(1'b0)) u_a (.clk(clk), .rst(rst), .bus(if_a.slave));
    count_reg_unit #(.WIDTH(2), .MAX_COUNT(3),  .SATURATE(1'b1)) u_b (.clk(clk), .rst(rst), .bus(if_b.slave));
    count_reg_unit #(.WIDTH(4), .MAX_COUNT(5),  .SATURATE(1'b0)) u_c (.clk(clk), .rst(rst), .bus(if_c.slave));
    count_reg_unit #(.WIDTH(4))                                   u_d (.clk(clk), .rst(rst), .bus(if_d.slave));

    typedef struct {
        logic r;
        logic e;
        int   cnt;
        logic tc;
        logic wr;
    } vec_t;

    vec_t vt[$];

    int n_vec = 0;
    int n_err = 0;

    // Reference model: instance i counts modulo (max+1) or saturates at max.
    int mc [4] = '{0, 0, 0, 0};
    int mw [4] = '{0, 0, 0, 0};
    int mx [4] = '{15, 3, 5, 15};
    int sat[4] = '{0, 1, 0, 0};

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic r, input logic e, input int c, input logic t, input logic w);
        vec_t v;
        v.r = r; v.e = e; v.cnt = c; v.tc = t; v.wr = w;
        vt.push_back(v);
    endtask

    // Apply one cycle, advance the model, compare every instance against it.
    task automatic step(input logic r, input logic e);
        int act_c[4];
        int act_t[4];
        int act_w[4];
        @(negedge clk);
        rst = r;
        en  = e;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (r) begin
                mc[i] = 0;
                mw[i] = 0;
            end else if (e) begin
                if (sat[i] != 0) begin
                    mc[i] = (mc[i] < mx[i]) ? mc[i] + 1 : mx[i];
                    mw[i] = 0;
                end else begin
                    mw[i] = (mc[i] == mx[i]) ? 1 : 0;
                    mc[i] = (mc[i] + 1) % (mx[i] + 1);
                end
            end else begin
                mw[i] = 0;
            end
        end
        act_c[0] = int'(if_a.count); act_t[0] = int'(if_a.tc); act_w[0] = int'(if_a.wrapped);
        act_c[1] = int'(if_b.count); act_t[1] = int'(if_b.tc); act_w[1] = int'(if_b.wrapped);
        act_c[2] = int'(if_c.count); act_t[2] = int'(if_c.tc); act_w[2] = int'(if_c.wrapped);
        act_c[3] = int'(narrow);     act_t[3] = int'(if_d.tc); act_w[3] = int'(if_d.wrapped);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("model_count[%0d]", i), act_c[i], (i == 3) ? (mc[i] % 4) : mc[i]);
            chk($sformatf("model_tc[%0d]", i), act_t[i], (mc[i] == mx[i]) ? 1 : 0);
            chk($sformatf("model_wrapped[%0d]", i), act_w[i], mw[i]);
        end
    endtask

    initial begin
        int exp_b[8] = '{1, 2, 3, 3, 3, 3, 3, 3};
        int exp_c[8] = '{1, 2, 3, 4, 5, 0, 1, 2};
        int exp_d[8] = '{1, 2, 3, 0, 1, 2, 3, 0};
        int c;

        // Power-up value before any reset edge.
        #1;
        chk("powerup_count_a", int'(if_a.count), 0);
        chk("powerup_wrapped_a", int'(if_a.wrapped), 0);
        chk("powerup_count_b", int'(if_b.count), 0);

        // Directed table for the default instance.
        add(1'b1, 1'b0, 0, 1'b0, 1'b0);
        add(1'b1, 1'b1, 0, 1'b0, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            c = i % 16;
            add(1'b0, 1'b1, c, (c == 15), (i == 16));
        end
        add(1'b1, 1'b0, 0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1, 1'b0, 1'b0);
        add(1'b0, 1'b1, 2, 1'b0, 1'b0);
        add(1'b0, 1'b0, 2, 1'b0, 1'b0);
        add(1'b0, 1'b0, 2, 1'b0, 1'b0);
        add(1'b0, 1'b1, 3, 1'b0, 1'b0);
        for (int i = 4; i <= 9; i++) add(1'b0, 1'b1, i, 1'b0, 1'b0);
        add(1'b1, 1'b1, 0, 1'b0, 1'b0);
        add(1'b1, 1'b1, 0, 1'b0, 1'b0);
        add(1'b1, 1'b1, 0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1, 1'b0, 1'b0);

        foreach (vt[k]) begin
            step(vt[k].r, vt[k].e);
            chk($sformatf("table_count[%0d]", k), int'(if_a.count), vt[k].cnt);
            chk($sformatf("table_tc[%0d]", k), int'(if_a.tc), int'(vt[k].tc));
            chk($sformatf("table_wrapped[%0d]", k), int'(if_a.wrapped), int'(vt[k].wr));
        end

        // Saturate, short wrap and narrow-net sequences from reset.
        step(1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1);
            chk($sformatf("sat_count[%0d]", i), int'(if_b.count), exp_b[i]);
            chk($sformatf("sat_tc[%0d]", i), int'(if_b.tc), (i >= 2) ? 1 : 0);
            chk($sformatf("sat_wrapped[%0d]", i), int'(if_b.wrapped), 0);
            chk($sformatf("max5_count[%0d]", i), int'(if_c.count), exp_c[i]);
            chk($sformatf("max5_wrapped[%0d]", i), int'(if_c.wrapped), (i == 5) ? 1 : 0);
            chk($sformatf("narrow_count[%0d]", i), int'(narrow), exp_d[i]);
        end

        // Reset mid-count on the narrow instance (count=2) clears next edge.
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        chk("narrow_before_rst", int'(narrow), 2);
        step(1'b1, 1'b1);
        chk("narrow_after_rst", int'(narrow), 0);
        chk("sat_after_rst", int'(if_b.count), 0);

        // Randomised run against the model.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
